// File: rtl/if_id_stage.sv
// Fetch front-end and IF/ID pipeline register for the miniRV core, with ID-side immediate-format decode.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [24:0] sext_din,
  output logic [2:0]  sext_op
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] SEXT_I     = 3'b000;
  localparam logic [2:0] SEXT_SHAMT = 3'b001;
  localparam logic [2:0] SEXT_S     = 3'b010;
  localparam logic [2:0] SEXT_U     = 3'b011;
  localparam logic [2:0] SEXT_B     = 3'b100;
  localparam logic [2:0] SEXT_J     = 3'b101;
  localparam logic [2:0] SEXT_NONE  = 3'b111;

  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  // Redirect targets are forced word-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (!stall) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= 32'h0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_pc    <= 32'h0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_pc    <= pc;
      id_inst  <= irom_inst;
      id_valid <= 1'b1;
    end
  end

  assign irom_addr = pc;
  assign id_pc4    = id_pc + 32'd4;
  assign sext_din  = id_inst[31:7];
  assign opcode    = id_inst[6:0];
  assign funct3    = id_inst[14:12];

  // Immediate-format selector; unknown encodings map to the zero format.
  always_comb begin
    sext_op = SEXT_NONE;
    case (opcode)
      OP_IMM:    sext_op = (funct3 == 3'b001 || funct3 == 3'b101) ? SEXT_SHAMT : SEXT_I;
      OP_LOAD:   sext_op = SEXT_I;
      OP_JALR:   sext_op = SEXT_I;
      OP_STORE:  sext_op = SEXT_S;
      OP_LUI:    sext_op = SEXT_U;
      OP_AUIPC:  sext_op = SEXT_U;
      OP_BRANCH: sext_op = SEXT_B;
      OP_JAL:    sext_op = SEXT_J;
      default:   sext_op = SEXT_NONE;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  // Fetch counts advance edges; bubble counts both stall and flush edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else if (flush || stall) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end else begin
      perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: reset, decode table, stall/flush/wrap sequences and randomized traffic.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [24:0] sext_din;
  logic [2:0]  sext_op;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  logic [31:0] rom [256];
  assign irom_inst = rom[irom_addr[9:2]];

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .irom_addr(irom_addr), .irom_inst(irom_inst),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
    .sext_din(sext_din), .sext_op(sext_op)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc, m_idpc, m_inst;
  logic        m_valid;
  logic [31:0] m_fetch, m_bubble;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  op;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [2:0] ref_op(input logic [31:0] inst);
    logic [6:0] o;
    logic [2:0] f;
    o = inst[6:0];
    f = inst[14:12];
    if (o == 7'b0010011 && (f == 3'd1 || f == 3'd5)) return 3'b001;
    if (o == 7'b0010011 || o == 7'b0000011 || o == 7'b1100111) return 3'b000;
    if (o == 7'b0100011) return 3'b010;
    if (o == 7'b0110111 || o == 7'b0010111) return 3'b011;
    if (o == 7'b1100011) return 3'b100;
    if (o == 7'b1101111) return 3'b101;
    return 3'b111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " irom_addr"}, irom_addr, m_pc);
    check({tag, " id_pc"}, id_pc, m_idpc);
    check({tag, " id_pc4"}, id_pc4, m_idpc + 32'd4);
    check({tag, " id_inst"}, id_inst, m_inst);
    check({tag, " id_valid"}, 32'(id_valid), 32'(m_valid));
    check({tag, " sext_din"}, 32'(sext_din), 32'(m_inst[31:7]));
    check({tag, " sext_op"}, 32'(sext_op), 32'(ref_op(m_inst)));
`ifdef IF_PERF_CNT_EN
    check({tag, " perf_fetch"}, perf_fetch_cnt, m_fetch);
    check({tag, " perf_bubble"}, perf_bubble_cnt, m_bubble);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_idpc = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
    m_fetch = 32'h0; m_bubble = 32'h0;
  endtask

  // One rising edge; reference updated from the inputs held across it.
  task automatic tick(input string tag);
    logic [31:0] fetched;
    @(posedge clk);
    fetched = rom[m_pc[9:2]];
    if (rst) model_reset();
    else if (flush) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_idpc = 0; m_inst = 32'h13; m_valid = 0;
      m_bubble++;
    end else if (stall) m_bubble++;
    else begin
      m_idpc = m_pc; m_inst = fetched; m_valid = 1; m_pc = m_pc + 4;
      m_fetch++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] r);
    stall = s; flush = f; redirect_pc = r;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b1100111; ops[3] = 7'b0100011;
    ops[4] = 7'b0110111; ops[5] = 7'b0010111; ops[6] = 7'b1100011; ops[7] = 7'b1101111;
    ops[8] = 7'b0110011; ops[9] = 7'b0010011;

    vecs[0]  = '{32'hFE11_2E23, 3'b010};
    vecs[1]  = '{32'h0080_006F, 3'b101};
    vecs[2]  = '{32'h0040_9093, 3'b001};
    vecs[3]  = '{32'h1234_52B7, 3'b011};
    vecs[4]  = '{32'h0020_81B3, 3'b111};
    vecs[5]  = '{32'h0010_0093, 3'b000};
    vecs[6]  = '{32'h0000_A083, 3'b000};
    vecs[7]  = '{32'h0000_8067, 3'b000};
    vecs[8]  = '{32'h0000_0097, 3'b011};
    vecs[9]  = '{32'h0000_0063, 3'b100};
    vecs[10] = '{32'h4010_5093, 3'b001};
    vecs[11] = '{32'h0FF0_F093, 3'b000};

    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0010_0093;

    rst = 1'b1; drive(0, 0, 0); model_reset();
    #2;
    check_all("reset");
    #20;
    @(negedge clk); rst = 1'b0;
    tick("adv0");
    check("plan id_inst", id_inst, 32'h0010_0093);
    check("plan id_pc4", id_pc4, 32'h4);
    tick("adv1");
    check("plan irom_addr", irom_addr, 32'h8);

    // Asynchronous reset mid-cycle while stalling and flushing
    @(negedge clk); drive(1, 1, 32'h40); #2; rst = 1'b1; #1;
    model_reset();
    check_all("async_rst");
    tick("rst_held");
    @(negedge clk); rst = 1'b0; drive(0, 0, 0);

    // Table-driven decode
    for (int i = 0; i < 12; i++) begin
      rom[m_pc[9:2]] = vecs[i].inst;
      tick("vec");
      check("vec inst", id_inst, vecs[i].inst);
      check("vec op", 32'(sext_op), 32'(vecs[i].op));
      check("vec din", 32'(sext_din), 32'(vecs[i].inst[31:7]));
    end

    // Stall at PC=0x10
    @(negedge clk); drive(0, 1, 32'h10); tick("to10");
    @(negedge clk); drive(0, 0, 0); tick("fill");
    check("stall pre pc", irom_addr, 32'h14);
    @(negedge clk); drive(0, 1, 32'h10); tick("to10b");
    @(negedge clk); drive(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall pc", irom_addr, 32'h10);
    end
    @(negedge clk); drive(0, 0, 0); tick("unstall");
    check("unstall pc", irom_addr, 32'h14);
    check("unstall idpc", id_pc, 32'h10);

    // Flush with misaligned target, then flush+stall together
    @(negedge clk); drive(0, 1, 32'h0000_0102); tick("flush");
    check("flush pc", irom_addr, 32'h100);
    check("flush valid", 32'(id_valid), 32'h0);
    check("flush inst", id_inst, 32'h13);
    @(negedge clk); drive(0, 0, 0); tick("post_flush");
    check("post_flush idpc", id_pc, 32'h100);
    @(negedge clk); drive(1, 1, 32'h0000_0203); tick("flush_stall");
    check("flush_stall pc", irom_addr, 32'h200);

    // PC wrap
    @(negedge clk); drive(0, 1, 32'hFFFF_FFFF); tick("to_top");
    @(negedge clk); drive(0, 0, 0); tick("wrap");
    check("wrap pc", irom_addr, 32'h0);
    check("wrap pc4", id_pc4, 32'h0);

`ifdef IF_PERF_CNT_EN
    @(negedge clk); rst = 1'b1; #1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) tick("p_adv");
    @(negedge clk); drive(1, 0, 0); tick("p_st"); tick("p_st");
    @(negedge clk); drive(0, 1, 32'h80); tick("p_fl");
    check("perf fetch5", perf_fetch_cnt, 32'd5);
    check("perf bubble3", perf_bubble_cnt, 32'd3);
    @(negedge clk); drive(0, 0, 0);
`endif

    // Randomized traffic against the reference
    for (int i = 0; i < 256; i++)
      if (i % 2 == 0) rom[i] = {rom[i][31:7], ops[i % 10]};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom);
      if (($urandom % 50) == 0) rst = 1'b1; else rst = 1'b0;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch front-end plus IF/ID pipeline register for the five-stage miniRV core.
- Owns the PC, drives the combinational instruction ROM address, and latches the fetched instruction into the ID stage.
- In ID, combinationally derives the 25-bit immediate field and 3-bit immediate-format selector consumed by the downstream immediate sign-extension unit.
- Handles hazard stalls and branch/jump redirect flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction injected into ID on reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID register.
- flush  in  1  EX-resolved taken branch/jump: redirect fetch, squash ID.
- redirect_pc  in  32  target PC, valid when flush=1.
- irom_addr  out  32  current PC to instruction ROM (ROM uses [15:2]).
- irom_inst  in  32  combinational ROM read data for irom_addr.
- id_pc  out  32  PC of instruction in ID.
- id_pc4  out  32  id_pc + 4.
- id_inst  out  32  instruction in ID.
- id_valid  out  1  ID holds a real (non-bubble) instruction.
- sext_din  out  25  id_inst[31:7].
- sext_op  out  3  immediate format selector.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC; id_pc = 0; id_inst = NOP_INST; id_valid = 0.
  - Release is synchronous to the next rising edge.
- irom_addr = PC, combinational. Fetch latency: ROM data captured into ID at the edge ending that cycle, so one cycle PC→ID.
- Per rising edge, priority flush > stall > advance:
  - flush=1: PC <= {redirect_pc[31:2],2'b00}; id_inst <= NOP_INST; id_valid <= 0; id_pc <= 0. Also wins when stall=1 in the same cycle.
  - stall=1 (flush=0): PC, id_pc, id_inst, id_valid all hold.
  - Otherwise: PC <= PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); id_pc <= PC; id_inst <= irom_inst; id_valid <= 1.
- id_pc4 = id_pc + 4, combinational, 32-bit wrap.
- sext_din = id_inst[31:7], combinational.
- sext_op, combinational from id_inst opcode (bits 6:0) and funct3 (bits 14:12):
  - 0010011 with funct3 001 or 101 (shift-imm) → 001.
  - 0010011 other funct3, 0000011 (load), 1100111 (jalr) → 000 (I-type).
  - 0100011 (store) → 010.
  - 0110111 (lui), 0010111 (auipc) → 011.
  - 1100011 (branch) → 100.
  - 1101111 (jal) → 101.
  - Anything else (R-type, illegal) → 111, which the extender maps to zero.
- Bubble (id_valid=0) still presents NOP_INST, so sext_op = 000 and sext_din = 25'h000000.
- Reset asserted mid-stall or mid-flush: reset wins unconditionally.
- No internal state beyond PC, the ID register and optional counters.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every advance edge.
  - perf_bubble_cnt increments on every flush edge and every stall edge.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-cycle → irom_addr=0 immediately, id_inst=32'h13, id_valid=0, sext_op=000; release, ROM returns 32'h0010_0093 → next edge id_inst=32'h0010_0093, id_pc=0, id_pc4=4, irom_addr=8 after 2nd edge.
- Straight-line decode: feed 32'hFE11_2E23 (sw) → sext_op=010, sext_din=inst[31:7]; 32'h0080_006F (jal) → 101; 32'h0040_9093 (slli) → 001; 32'h1234_52B7 (lui) → 011; 32'h0020_81B3 (add) → 111.
- Stall: PC=0x10, stall=1 for 3 cycles → irom_addr stays 0x10, id_inst/id_pc unchanged; deassert → PC=0x14 next edge.
- Flush: flush=1, redirect_pc=0x0000_0102 → PC=0x100, id_valid=0, id_inst=0x13 after one edge; next edge id_pc=0x100.
- Flush+stall same cycle → flush behaviour (PC=redirect); wrap: PC=0xFFFF_FFFC advance → PC=0.
- IF_PERF_CNT_EN: 5 advances, 2 stalls, 1 flush → perf_fetch_cnt=5, perf_bubble_cnt=3.
